// File: rtl/pkt_mem_ctrl.sv
// Packet buffer controller: writes one framed packet into a 2^AWIDTH-word RAM,
// captures its length, then sequences the readout under a ready handshake.
module pkt_mem_ctrl #(
   parameter int unsigned AWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              val_i,
   input  logic              sop_i,
   input  logic              eop_i,
   input  logic              clr_i,
   input  logic              rd_ready_i,
   output logic              wren_o,
   output logic [AWIDTH-1:0] wraddr_o,
   output logic              rden_o,
   output logic [AWIDTH-1:0] rdaddr_o,
   output logic              rd_last_o,
   output logic              busy_o,
   output logic [AWIDTH:0]   pkt_len_o,
   output logic              ovf_o,
   output logic              err_o
);

   localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2,
      READ  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [AWIDTH:0]     cnt_q, cnt_d;
   logic [AWIDTH-1:0]   rdaddr_q, rdaddr_d;
   logic [AWIDTH:0]     pkt_len_q, pkt_len_d;
   logic                busy_q;
   logic                ovf_q, ovf_d;
   logic                err_q, err_d;
   logic                restart;
   logic [AWIDTH:0]     len_m1;

   assign len_m1 = pkt_len_q - 1'b1;

   // A SOP inside a packet restarts at address 0 in the same cycle, so the
   // registered count is overridden for that one word.
   assign restart  = (state_q == WRITE) && val_i && sop_i && !clr_i;
   assign wraddr_o = restart ? '0 : cnt_q[AWIDTH-1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdaddr_d  = rdaddr_q;
      pkt_len_d = pkt_len_q;
      ovf_d     = 1'b0;
      err_d     = 1'b0;
      wren_o    = 1'b0;
      rden_o    = 1'b0;
      rd_last_o = 1'b0;

      if (clr_i) begin
         state_d  = IDLE;
         cnt_d    = '0;
         rdaddr_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (val_i && sop_i) begin
                  wren_o = 1'b1;
                  cnt_d  = {{AWIDTH{1'b0}}, 1'b1};
                  if (eop_i) begin
                     pkt_len_d = {{AWIDTH{1'b0}}, 1'b1};
                     state_d   = READ;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
            WRITE: begin
               if (val_i) begin
                  if (sop_i) begin
                     err_d  = 1'b1;
                     wren_o = 1'b1;
                     cnt_d  = {{AWIDTH{1'b0}}, 1'b1};
                  end else if (cnt_q == DEPTH_C) begin
                     ovf_d = 1'b1;
                     if (eop_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                     end else begin
                        state_d = DROP;
                     end
                  end else begin
                     wren_o = 1'b1;
                     cnt_d  = cnt_q + 1'b1;
                     if (eop_i) begin
                        pkt_len_d = cnt_q + 1'b1;
                        state_d   = READ;
                     end
                  end
               end
            end
            DROP: begin
               if (val_i && eop_i) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            READ: begin
               rden_o    = rd_ready_i;
               rd_last_o = (rdaddr_q == len_m1[AWIDTH-1:0]);
               if (rd_ready_i) begin
                  if (rd_last_o) begin
                     rdaddr_d = '0;
                     cnt_d    = '0;
                     state_d  = IDLE;
                  end else begin
                     rdaddr_d = rdaddr_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rdaddr_q  <= '0;
         pkt_len_q <= '0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdaddr_q  <= rdaddr_d;
         pkt_len_q <= pkt_len_d;
         busy_q    <= (state_d == READ);
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   assign rdaddr_o  = rdaddr_q;
   assign busy_o    = busy_q;
   assign pkt_len_o = pkt_len_q;
   assign ovf_o     = ovf_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_pkt_mem_ctrl.sv
// Directed bench for pkt_mem_ctrl with a 4-word buffer: framing, overflow,
// SOP restart, stalled readout, clear and reset behaviour.
module tb_pkt_mem_ctrl;

   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          srst, val, sop, eop, clr, rdy;
   logic          wren, rden, rd_last, busy, ovf, err;
   logic [AW-1:0] wraddr, rdaddr;
   logic [AW:0]   pkt_len;

   int checks = 0;
   int errors = 0;

   pkt_mem_ctrl #(.AWIDTH(AW)) dut (
      .clk_i(clk), .srst_i(srst), .val_i(val), .sop_i(sop), .eop_i(eop),
      .clr_i(clr), .rd_ready_i(rdy), .wren_o(wren), .wraddr_o(wraddr),
      .rden_o(rden), .rdaddr_o(rdaddr), .rd_last_o(rd_last), .busy_o(busy),
      .pkt_len_o(pkt_len), .ovf_o(ovf), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic s, input logic e,
                        input logic c, input logic r);
      val = v; sop = s; eop = e; clr = c; rdy = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      srst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      srst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (wraddr !== 2'd0) begin errors++; $display("FAIL reset_wraddr got=%0d exp=0", wraddr); end
      checks++; if (rdaddr !== 2'd0) begin errors++; $display("FAIL reset_rdaddr got=%0d exp=0", rdaddr); end
      checks++; if ({busy, ovf, err, wren, rden, rd_last} !== 6'b0) begin errors++; $display("FAIL reset_flags got=%b exp=000000", {busy, ovf, err, wren, rden, rd_last}); end
      checks++; if (pkt_len !== 3'd0) begin errors++; $display("FAIL reset_pkt_len got=%0d exp=0", pkt_len); end
   endtask

   task automatic test_three_word();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i == 0, i == 2, 1'b0, 1'b0);
         checks++; if (wren !== 1'b1) begin errors++; $display("FAIL w3_wren[%0d] got=%b exp=1", i, wren); end
         checks++; if (wraddr !== 2'(i)) begin errors++; $display("FAIL w3_wraddr[%0d] got=%0d exp=%0d", i, wraddr, i); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL w3_busy_early[%0d] got=%b exp=0", i, busy); end
         tick();
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL w3_busy got=%b exp=1", busy); end
      checks++; if (pkt_len !== 3'd3) begin errors++; $display("FAIL w3_pkt_len got=%0d exp=3", pkt_len); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         checks++; if (rden !== 1'b1) begin errors++; $display("FAIL r3_rden[%0d] got=%b exp=1", i, rden); end
         checks++; if (rdaddr !== 2'(i)) begin errors++; $display("FAIL r3_rdaddr[%0d] got=%0d exp=%0d", i, rdaddr, i); end
         checks++; if (rd_last !== (i == 2)) begin errors++; $display("FAIL r3_rd_last[%0d] got=%b exp=%b", i, rd_last, i == 2); end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL r3_busy_end got=%b exp=0", busy); end
      checks++; if (rdaddr !== 2'd0) begin errors++; $display("FAIL r3_rdaddr_end got=%0d exp=0", rdaddr); end
   endtask

   task automatic test_one_word();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (wren !== 1'b1 || wraddr !== 2'd0) begin errors++; $display("FAIL w1_write got=%b/%0d exp=1/0", wren, wraddr); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b1 || pkt_len !== 3'd1) begin errors++; $display("FAIL w1_len got=%b/%0d exp=1/1", busy, pkt_len); end
      checks++; if (rd_last !== 1'b1 || rden !== 1'b0) begin errors++; $display("FAIL w1_last_stall got=%b/%b exp=1/0", rd_last, rden); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (rden !== 1'b1 || rd_last !== 1'b1) begin errors++; $display("FAIL w1_read got=%b/%b exp=1/1", rden, rd_last); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL w1_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_full_and_overflow();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i == 0, i == 3, 1'b0, 1'b0);
         checks++; if (wren !== 1'b1 || wraddr !== 2'(i)) begin errors++; $display("FAIL w4_write[%0d] got=%b/%0d exp=1/%0d", i, wren, wraddr, i); end
         tick();
      end
      checks++; if (pkt_len !== 3'd4 || ovf !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL w4_len got=%0d/%b/%b exp=4/0/1", pkt_len, ovf, busy); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         checks++; if (rdaddr !== 2'(i) || rd_last !== (i == 3)) begin errors++; $display("FAIL r4_read[%0d] got=%0d/%b exp=%0d/%b", i, rdaddr, rd_last, i, i == 3); end
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i == 0, i == 5, 1'b0, 1'b0);
         checks++; if (wren !== (i < 4)) begin errors++; $display("FAIL w6_wren[%0d] got=%b exp=%b", i, wren, i < 4); end
         tick();
         checks++; if (ovf !== (i == 4)) begin errors++; $display("FAIL w6_ovf[%0d] got=%b exp=%b", i, ovf, i == 4); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL w6_busy[%0d] got=%b exp=0", i, busy); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (pkt_len !== 3'd4 || wraddr !== 2'd0) begin errors++; $display("FAIL w6_after got=%0d/%0d exp=4/0", pkt_len, wraddr); end
   endtask

   task automatic test_sop_restart();
      logic [1:0] exp_addr [5];
      exp_addr = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, i == 0 || i == 2, i == 4, 1'b0, 1'b0);
         checks++; if (wren !== 1'b1 || wraddr !== exp_addr[i]) begin errors++; $display("FAIL sop_write[%0d] got=%b/%0d exp=1/%0d", i, wren, wraddr, exp_addr[i]); end
         tick();
         checks++; if (err !== (i == 2)) begin errors++; $display("FAIL sop_err[%0d] got=%b exp=%b", i, err, i == 2); end
      end
      checks++; if (pkt_len !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL sop_len got=%0d/%b exp=3/1", pkt_len, busy); end
   endtask

   task automatic test_rd_stall();
      logic       pat   [5];
      logic [1:0] exp_a [5];
      int         nrd;
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_a = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
      nrd   = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, i == 1, 1'b0, pat[i]);
         if (rden) nrd++;
         checks++; if (wren !== 1'b0) begin errors++; $display("FAIL stall_wren[%0d] got=%b exp=0", i, wren); end
         checks++; if (rdaddr !== exp_a[i] || rden !== pat[i]) begin errors++; $display("FAIL stall_rd[%0d] got=%0d/%b exp=%0d/%b", i, rdaddr, rden, exp_a[i], pat[i]); end
         checks++; if (rd_last !== (i == 4)) begin errors++; $display("FAIL stall_last[%0d] got=%b exp=%b", i, rd_last, i == 4); end
         tick();
         checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL stall_pulse[%0d] got=%b/%b exp=0/0", i, err, ovf); end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (nrd != 3) begin errors++; $display("FAIL stall_count got=%0d exp=3", nrd); end
      checks++; if (busy !== 1'b0 || rdaddr !== 2'd0) begin errors++; $display("FAIL stall_end got=%b/%0d exp=0/0", busy, rdaddr); end
   endtask

   task automatic test_clr_and_srst();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL clrw_wren got=%b exp=0", wren); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (wraddr !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL clrw_state got=%0d/%b exp=0/0", wraddr, busy); end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (wraddr !== 2'd1) begin errors++; $display("FAIL clr_next_wraddr got=%0d exp=1", wraddr); end
      tick();
      checks++; if (pkt_len !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL clr_next_len got=%0d/%b exp=2/1", pkt_len, busy); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++; if (rden !== 1'b0) begin errors++; $display("FAIL clrr_rden got=%b exp=0", rden); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b0 || rdaddr !== 2'd0 || wraddr !== 2'd0) begin errors++; $display("FAIL clrr_state got=%b/%0d/%0d exp=0/0/0", busy, rdaddr, wraddr); end
      checks++; if (pkt_len !== 3'd2) begin errors++; $display("FAIL clrr_len_hold got=%0d exp=2", pkt_len); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i == 0, i == 2, 1'b0, 1'b0); tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
      checks++; if (rdaddr !== 2'd1) begin errors++; $display("FAIL srst_pre_rdaddr got=%0d exp=1", rdaddr); end
      srst = 1'b1;
      tick();
      srst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (busy !== 1'b0 || rdaddr !== 2'd0 || wraddr !== 2'd0) begin errors++; $display("FAIL srst_state got=%b/%0d/%0d exp=0/0/0", busy, rdaddr, wraddr); end
      checks++; if (pkt_len !== 3'd0 || rden !== 1'b0) begin errors++; $display("FAIL srst_len got=%0d/%b exp=0/0", pkt_len, rden); end
   endtask

   initial begin
      srst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_three_word();
      test_one_word();
      test_full_and_overflow();
      test_sop_restart();
      test_rd_stall();
      test_clr_and_srst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
